// File: rtl/dma_pkg.sv
// Shared encodings for the ping-pong DMA engine: transfer direction, FSM states, bank index.
package dma_pkg;

    localparam logic DIR_CPU_TO_MEM = 1'b1;
    localparam logic DIR_MEM_TO_CPU = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef logic bank_idx_t;

endpackage

// File: rtl/dma_bank.sv
// One ping-pong bank: DEPTH x WIDE_W storage with fill count, sealed flag and
// wide/narrow slicing on each side, selected by the latched transfer direction.
module dma_bank
    import dma_pkg::*;
#(
    parameter int WIDE_W   = 8,
    parameter int NARROW_W = 4,
    parameter int DEPTH    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dir_i,
    input  logic              wr_en_i,
    input  logic [WIDE_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    input  logic              rd_en_i,
    output logic              sealed_o,
    output logic              wr_word_o,
    output logic              seal_o,
    output logic              rd_word_o,
    output logic              free_o,
    output logic [WIDE_W-1:0] rd_data_o
);

    localparam int R  = WIDE_W / NARROW_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (R > 1) ? $clog2(R) : 1;

    logic [CW-1:0]     cnt_q, cnt_d, rd_q, rd_d;
    logic [BW-1:0]     wbeat_q, wbeat_d, rbeat_q, rbeat_d;
    logic              sealed_q, sealed_d;
    logic [WIDE_W-1:0] mem_q [DEPTH];
    logic [WIDE_W-1:0] rd_word_data;
    logic [NARROW_W-1:0] rd_slice;
    logic              rd_narrow, wr_narrow;

    assign rd_narrow = (dir_i == DIR_CPU_TO_MEM);
    assign wr_narrow = !rd_narrow;

    // A word completes on the wide beat, or on the last narrow slice.
    assign wr_word_o = wr_en_i && (!wr_narrow || wbeat_q == BW'(R - 1));
    assign seal_o    = wr_word_o && ((cnt_q == CW'(DEPTH - 1)) || wr_last_i);
    assign rd_word_o = rd_en_i && (!rd_narrow || rbeat_q == BW'(R - 1));
    assign free_o    = rd_word_o && ((rd_q + CW'(1)) == cnt_q);
    assign sealed_o  = sealed_q;

    always_comb begin
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wbeat_d  = wbeat_q;
        rbeat_d  = rbeat_q;
        sealed_d = sealed_q;
        if (wr_en_i && wr_narrow) wbeat_d = wr_word_o ? '0 : wbeat_q + BW'(1);
        if (wr_word_o)            cnt_d   = cnt_q + CW'(1);
        if (seal_o)               sealed_d = 1'b1;
        if (rd_en_i && rd_narrow) rbeat_d = rd_word_o ? '0 : rbeat_q + BW'(1);
        if (rd_word_o)            rd_d    = rd_q + CW'(1);
        if (free_o) begin
            sealed_d = 1'b0;
            cnt_d    = '0;
            rd_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= '0;
            rd_q     <= '0;
            wbeat_q  <= '0;
            rbeat_q  <= '0;
            sealed_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wbeat_q  <= wbeat_d;
            rbeat_q  <= rbeat_d;
            sealed_q <= sealed_d;
        end
    end

    // Storage is not reset; the sealed flag and counters define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int s = 0; s < R; s++) begin
                if (!wr_narrow || wbeat_q == BW'(s))
                    mem_q[cnt_q[AW-1:0]][s*NARROW_W +: NARROW_W] <=
                        wr_narrow ? wr_data_i[NARROW_W-1:0] : wr_data_i[s*NARROW_W +: NARROW_W];
            end
        end
    end

    always_comb begin
        rd_word_data = mem_q[rd_q[AW-1:0]];
        rd_slice     = '0;
        for (int s = 0; s < R; s++) begin
            if (rbeat_q == BW'(s)) rd_slice = rd_word_data[s*NARROW_W +: NARROW_W];
        end
    end

    assign rd_data_o = rd_narrow ? WIDE_W'(rd_slice) : rd_word_data;

endmodule

// File: rtl/dma_pingpong_xfer.sv
// Ping-pong DMA top: start/busy/done FSM, word totals, producer/consumer bank
// pointers and direction-dependent port muxing around two dma_bank instances.
module dma_pingpong_xfer
    import dma_pkg::*;
#(
    parameter int WIDE_W   = 8,
    parameter int NARROW_W = 4,
    parameter int DEPTH    = 8,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                dir,
    input  logic [LEN_W-1:0]    xfer_len,
    output logic                busy,
    output logic                done,
    input  logic                cpu_in_valid,
    output logic                cpu_in_ready,
    input  logic [WIDE_W-1:0]   cpu_in_data,
    output logic                cpu_out_valid,
    input  logic                cpu_out_ready,
    output logic [WIDE_W-1:0]   cpu_out_data,
    input  logic                mem_in_valid,
    output logic                mem_in_ready,
    input  logic [NARROW_W-1:0] mem_in_data,
    output logic                mem_out_valid,
    input  logic                mem_out_ready,
    output logic [NARROW_W-1:0] mem_out_data
);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] len_q, len_d, wr_tot_q, wr_tot_d, rd_tot_q, rd_tot_d;
    bank_idx_t        p_q, p_d, c_q, c_d;

    logic              prod_rdy, cons_vld, prod_vld, cons_rdy, prod_fire, cons_fire, wr_last;
    logic [1:0]        wr_en, rd_en, sealed, wr_word, seal, rd_word, freed;
    logic [WIDE_W-1:0] rd_data [2];
    logic [WIDE_W-1:0] wr_data, cons_data;

    assign prod_rdy  = (state_q == ST_RUN) && !sealed[p_q] && (wr_tot_q < len_q);
    assign cons_vld  = (state_q == ST_RUN) && sealed[c_q];
    assign prod_vld  = (dir_q == DIR_CPU_TO_MEM) ? cpu_in_valid : mem_in_valid;
    assign cons_rdy  = (dir_q == DIR_CPU_TO_MEM) ? mem_out_ready : cpu_out_ready;
    assign prod_fire = prod_rdy && prod_vld;
    assign cons_fire = cons_vld && cons_rdy;
    assign wr_data   = (dir_q == DIR_CPU_TO_MEM) ? cpu_in_data : WIDE_W'(mem_in_data);
    assign wr_last   = ((wr_tot_q + LEN_W'(1)) == len_q);
    assign cons_data = rd_data[c_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_en[b] = prod_fire && (p_q == bank_idx_t'(b));
        assign rd_en[b] = cons_fire && (c_q == bank_idx_t'(b));

        dma_bank #(
            .WIDE_W  (WIDE_W),
            .NARROW_W(NARROW_W),
            .DEPTH   (DEPTH)
        ) u_bank (
            .clk      (clk),
            .resetn   (resetn),
            .dir_i    (dir_q),
            .wr_en_i  (wr_en[b]),
            .wr_data_i(wr_data),
            .wr_last_i(wr_last),
            .rd_en_i  (rd_en[b]),
            .sealed_o (sealed[b]),
            .wr_word_o(wr_word[b]),
            .seal_o   (seal[b]),
            .rd_word_o(rd_word[b]),
            .free_o   (freed[b]),
            .rd_data_o(rd_data[b])
        );
    end

    // Unselected ports stay quiet; data outputs read as zero unless valid.
    assign cpu_in_ready  = prod_rdy && (dir_q == DIR_CPU_TO_MEM);
    assign mem_in_ready  = prod_rdy && (dir_q == DIR_MEM_TO_CPU);
    assign cpu_out_valid = cons_vld && (dir_q == DIR_MEM_TO_CPU);
    assign mem_out_valid = cons_vld && (dir_q == DIR_CPU_TO_MEM);
    assign cpu_out_data  = cpu_out_valid ? cons_data : '0;
    assign mem_out_data  = mem_out_valid ? cons_data[NARROW_W-1:0] : '0;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_FIN);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        len_d    = len_q;
        wr_tot_d = wr_tot_q;
        rd_tot_d = rd_tot_q;
        p_d      = p_q;
        c_d      = c_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d    = dir;
                    len_d    = xfer_len;
                    wr_tot_d = '0;
                    rd_tot_d = '0;
                    p_d      = '0;
                    c_d      = '0;
                    state_d  = (xfer_len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (|wr_word) wr_tot_d = wr_tot_q + LEN_W'(1);
                if (|rd_word) begin
                    rd_tot_d = rd_tot_q + LEN_W'(1);
                    if ((rd_tot_q + LEN_W'(1)) == len_q) state_d = ST_FIN;
                end
                if (|seal)  p_d = ~p_q;
                if (|freed) c_d = ~c_q;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            len_q    <= '0;
            wr_tot_q <= '0;
            rd_tot_q <= '0;
            p_q      <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            len_q    <= len_d;
            wr_tot_q <= wr_tot_d;
            rd_tot_q <= rd_tot_d;
            p_q      <= p_d;
            c_q      <= c_d;
        end
    end

endmodule
